// File: rtl/ising_config.sv
// GPIO word field layout shared by the configuration register slice.
package ising_config;
    localparam int GPIO_STROBE_BIT = 31;
    localparam int GPIO_ADDR_MSB   = 30;
    localparam int GPIO_ADDR_LSB   = 16;
    localparam int GPIO_DATA_MSB   = 15;
    localparam int GPIO_DATA_LSB   = 0;
    localparam int GPIO_ADDR_W     = 15;
endpackage

// File: rtl/gpio_strobe_edge.sv
// Rising-edge detector for the GPIO write strobe; the previous-strobe flop tracks
// the input even in reset so a strobe held through reset never fires.
module gpio_strobe_edge (
    input  logic clk,
    input  logic rst,
    input  logic strobe_in,
    output logic strobe_rise
);
    logic strobe_q;

    always_ff @(posedge clk) begin
        strobe_q <= strobe_in;
    end

    assign strobe_rise = strobe_in & ~strobe_q & ~rst;
endmodule

// File: rtl/config_reg.sv
// GPIO-written configuration register, assembled from NUM_CHUNKS chunk writes.
// Optional macro CONFIG_REG_UPDATE_PULSE_EN adds a one-cycle update_pulse output.
module config_reg
    import ising_config::*;
#(
    parameter int                     DATA_WIDTH  = 16,
    parameter int                     NUM_CHUNKS  = 1,
    parameter int                     CHUNK_WIDTH = 16,
    parameter logic [GPIO_ADDR_W-1:0] ADDR        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           gpio_in,
    output logic [DATA_WIDTH-1:0] reg_out
`ifdef CONFIG_REG_UPDATE_PULSE_EN
    ,
    output logic                  update_pulse
`endif
);
    localparam int SHADOW_W = NUM_CHUNKS * CHUNK_WIDTH;
    localparam int EXT_W    = (SHADOW_W > DATA_WIDTH) ? SHADOW_W : DATA_WIDTH;
    localparam int CNT_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    logic                   strobe_rise;
    logic                   hit;
    logic                   last;
    logic [CNT_W-1:0]       idx;
    logic [SHADOW_W-1:0]    shadow;
    logic [SHADOW_W-1:0]    next_shadow;
    logic [EXT_W-1:0]       ext;
    logic [CHUNK_WIDTH-1:0] chunk;

    gpio_strobe_edge u_edge (
        .clk         (clk),
        .rst         (rst),
        .strobe_in   (gpio_in[GPIO_STROBE_BIT]),
        .strobe_rise (strobe_rise)
    );

    assign hit   = strobe_rise && (gpio_in[GPIO_ADDR_MSB:GPIO_ADDR_LSB] == ADDR);
    assign last  = (idx == CNT_W'(NUM_CHUNKS - 1));
    assign chunk = gpio_in[GPIO_DATA_LSB +: CHUNK_WIDTH];

    // Merge the incoming chunk so a completing write lands in reg_out on the same edge.
    always_comb begin
        next_shadow = shadow;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (idx == CNT_W'(i)) next_shadow[i*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk;
        end
    end

    assign ext = EXT_W'(next_shadow);

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_out <= '0;
            shadow  <= '0;
            idx     <= '0;
        end else if (hit) begin
            shadow <= next_shadow;
            if (last) begin
                idx     <= '0;
                reg_out <= ext[DATA_WIDTH-1:0];
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef CONFIG_REG_UPDATE_PULSE_EN
    always_ff @(posedge clk) begin
        if (rst) update_pulse <= 1'b0;
        else     update_pulse <= hit && last;
    end
`endif
endmodule

// File: tb/tb_config_reg.sv
// Directed bench: single-chunk, two-chunk and narrow-chunk instances of config_reg.
module tb_config_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ga  = '0;
    logic [31:0] gb  = '0;
    logic [31:0] gc  = '0;
    logic [15:0] ra;
    logic [31:0] rb;
    logic [7:0]  rc;
    int total = 0;
    int bad   = 0;
`ifdef CONFIG_REG_UPDATE_PULSE_EN
    logic pa, pb, pc;
`endif

    always #5 clk = ~clk;

    config_reg #(16, 1, 16, 15'd5) dut_a (
        .clk(clk), .rst(rst), .gpio_in(ga), .reg_out(ra)
`ifdef CONFIG_REG_UPDATE_PULSE_EN
        , .update_pulse(pa)
`endif
    );
    config_reg #(32, 2, 16, 15'd5) dut_b (
        .clk(clk), .rst(rst), .gpio_in(gb), .reg_out(rb)
`ifdef CONFIG_REG_UPDATE_PULSE_EN
        , .update_pulse(pb)
`endif
    );
    config_reg #(8, 3, 4, 15'h7FFF) dut_c (
        .clk(clk), .rst(rst), .gpio_in(gc), .reg_out(rc)
`ifdef CONFIG_REG_UPDATE_PULSE_EN
        , .update_pulse(pc)
`endif
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        total++; if (ra !== 16'h0) begin bad++; $display("FAIL reset_a got=%h exp=0000", ra); end
        total++; if (rb !== 32'h0) begin bad++; $display("FAIL reset_b got=%h exp=00000000", rb); end
        total++; if (rc !== 8'h0) begin bad++; $display("FAIL reset_c got=%h exp=00", rc); end
`ifdef CONFIG_REG_UPDATE_PULSE_EN
        total++; if (pa !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", pa); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_foreign_addr();
        ga = 32'h8006_BEEF; tick();
        ga = 32'h0;         tick();
        total++; if (ra !== 16'h0) begin bad++; $display("FAIL foreign_addr got=%h exp=0000", ra); end
    endtask

    task automatic test_single_write();
        ga = 32'h8005_1234; tick();
        total++; if (ra !== 16'h1234) begin bad++; $display("FAIL single_write got=%h exp=1234", ra); end
`ifdef CONFIG_REG_UPDATE_PULSE_EN
        total++; if (pa !== 1'b1) begin bad++; $display("FAIL pulse_high got=%b exp=1", pa); end
`endif
        ga = 32'h0; tick();
        total++; if (ra !== 16'h1234) begin bad++; $display("FAIL single_hold got=%h exp=1234", ra); end
`ifdef CONFIG_REG_UPDATE_PULSE_EN
        total++; if (pa !== 1'b0) begin bad++; $display("FAIL pulse_low got=%b exp=0", pa); end
`endif
    endtask

    task automatic test_held_strobe();
        ga = 32'h8005_1111; tick(10);
        ga = 32'h8005_2222; tick(3);
        total++; if (ra !== 16'h1111) begin bad++; $display("FAIL held_strobe got=%h exp=1111", ra); end
        ga = 32'h0;         tick();
        ga = 32'h8005_2222; tick();
        total++; if (ra !== 16'h2222) begin bad++; $display("FAIL rearm got=%h exp=2222", ra); end
        ga = 32'h0; tick();
    endtask

    task automatic test_two_chunk();
        gb = 32'h8005_CDEF; tick();
        total++; if (rb !== 32'h0) begin bad++; $display("FAIL two_chunk_partial got=%h exp=00000000", rb); end
        gb = 32'h0;         tick();
        gb = 32'h8007_AAAA; tick();
        gb = 32'h0;         tick();
        total++; if (rb !== 32'h0) begin bad++; $display("FAIL two_chunk_foreign got=%h exp=00000000", rb); end
        gb = 32'h8005_89AB; tick();
        total++; if (rb !== 32'h89AB_CDEF) begin bad++; $display("FAIL two_chunk_done got=%h exp=89abcdef", rb); end
        gb = 32'h0; tick();
    endtask

    task automatic test_narrow_chunks();
        gc = 32'hFFFF_0FFA; tick();
        gc = 32'h0;         tick();
        gc = 32'hFFFF_00F5; tick();
        gc = 32'h0;         tick();
        total++; if (rc !== 8'h0) begin bad++; $display("FAIL narrow_partial got=%h exp=00", rc); end
        gc = 32'hFFFF_0003; tick();
        total++; if (rc !== 8'h5A) begin bad++; $display("FAIL narrow_done got=%h exp=5a", rc); end
        gc = 32'h0; tick();
    endtask

    task automatic test_reset_mid();
        gb = 32'h8005_1111; tick();
        gb = 32'h0;         tick();
        gb = 32'h8005_2222; rst = 1'b1; tick(2);
        total++; if (rb !== 32'h0) begin bad++; $display("FAIL mid_reset got=%h exp=00000000", rb); end
        rst = 1'b0; tick(2);
        total++; if (rb !== 32'h0) begin bad++; $display("FAIL release_no_write got=%h exp=00000000", rb); end
        gb = 32'h0;         tick();
        gb = 32'h8005_3333; tick();
        total++; if (rb !== 32'h0) begin bad++; $display("FAIL post_reset_partial got=%h exp=00000000", rb); end
        gb = 32'h0;         tick();
        gb = 32'h8005_4444; tick();
        total++; if (rb !== 32'h4444_3333) begin bad++; $display("FAIL post_reset_done got=%h exp=44443333", rb); end
        gb = 32'h0; tick();
    endtask

    initial begin
        test_reset();
        test_foreign_addr();
        test_single_write();
        test_held_strobe();
        test_two_chunk();
        test_narrow_chunks();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
